i2c_codec_config: RTL
=====================

Name: i2c_codec_config

Overview:
- Register-table sequencer sitting directly upstream of the 24-bit I2C write serializer.
- After reset, walks a fixed WM8731 configuration table.
- For each entry: presents a 24-bit word {device address, 7-bit register, 9-bit value}, pulses GO, and waits for the serializer's ready handshake.
- Re-issues an entry whose transaction stalls, flags a permanent failure, and reports completion to the audio datapath.

Parameters:
- NUM_REGS, 11, number of table entries sent (indices 0..NUM_REGS-1).
- DEV_ADDR, 8'h34, codec write address placed in bits [23:16].
- GAP_CYCLES, 16, idle clk cycles between a completed transaction and the next GO.
- TIMEOUT, 96, clk cycles allowed in one wait phase before the entry is re-issued.
- MAX_RETRY, 3, re-issues allowed per entry before entering ERROR.

Ports:
- clk  input  1  serializer clock; this block shares the serializer's clock domain.
- reset  input  1  asynchronous, active-low reset.
- iStart  input  1  level; re-runs the whole table when sampled high in DONE or ERROR.
- iReady  input  1  serializer oReady; high = idle/finished, low = transaction in progress.
- oGO  output  1  one-cycle start pulse to the serializer.
- oDATA  output  24  word to serialize; held stable from the GO cycle until the entry completes.
- oIndex  output  4  table index currently being sent.
- oDone  output  1  high while in DONE.
- oError  output  1  high while in ERROR.

Behaviour:
- Reset values: oGO=0, oDATA=24'h000000, oIndex=0, oDone=0, oError=0, state=LOAD, retry=0, cycle counter=0.
- Reset mid-operation aborts immediately; after release, sequencing restarts at index 0 automatically.
- State LOAD:
  - oDATA <= {DEV_ADDR, rom[oIndex]}.
  - Clear cycle counter; next state ISSUE.
- State ISSUE:
  - oGO=1 for exactly one cycle.
  - Next state WAIT_BUSY.
- State WAIT_BUSY:
  - Waits for iReady=0.
  - On iReady=0: clear counter, go to WAIT_DONE.
  - If counter reaches TIMEOUT: retry path.
- State WAIT_DONE:
  - Waits for iReady=1, then goes to GAP.
  - The serializer re-sends internally after a NACK, so a stuck bus shows up as a timeout here.
  - If counter reaches TIMEOUT: retry path.
- Retry path:
  - If retry < MAX_RETRY: retry <= retry+1, go to ISSUE. The new GO forces the serializer counter back to 0.
  - Otherwise go to ERROR.
- State GAP:
  - Counts GAP_CYCLES cycles.
  - Then: if oIndex == NUM_REGS-1, go to DONE; else oIndex+1, retry <= 0, go to LOAD.
- State DONE:
  - oDone=1.
  - iStart=1: oIndex <= 0, retry <= 0, go to LOAD.
- State ERROR:
  - oError=1; oIndex holds the failing entry.
  - iStart=1 restarts at index 0.
- iStart is ignored in all other states.
- iReady already low in ISSUE is not treated as an error. WAIT_BUSY accepts it immediately.
- Cycle counter:
  - 7 bits, saturating; never wraps.
  - Cleared on every state entry.
- Retry counter is 2 bits; oIndex is 4 bits, and NUM_REGS must be ≤16.
- Latency:
  - Reset release to first GO = 2 cycles (LOAD, ISSUE).
  - iReady rise to next GO = GAP_CYCLES+2 cycles.
- ROM contents (16-bit {reg[6:0], val[8:0]}), indices 0..10:
  - 16'h1E00 reset
  - 16'h0097 L line in mute
  - 16'h0297 R line in mute
  - 16'h0479 L HP 0dB
  - 16'h0679 R HP 0dB
  - 16'h0812 DAC select
  - 16'h0A00 digital path
  - 16'h0C00 power on
  - 16'h0E42 I2S master 16-bit
  - 16'h1000 48 kHz normal mode
  - 16'h1201 active
- Out-of-range ROM index returns 16'h0000.

Decomposition:
- Shared package i2c_cfg_pkg holds:
  - state encoding (LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, DONE, ERROR)
  - WM8731 register address constants
  - DEV_ADDR default
- One sub-module: i2c_codec_rom. It is combinational, maps the 4-bit index to the 16-bit entry, and keeps table edits out of the FSM.

Test Plan:
- Normal run: the serializer model drops iReady 1 cycle after GO and raises it 40 cycles later. Required: 11 GO pulses; oDATA sequence 24'h341E00, 24'h340097 … 24'h341201; gaps of exactly 18 cycles between iReady rise and GO; oDone=1 after index 10.
- Stall: for index 3, the model holds iReady=0 forever. Required: GO re-issued at TIMEOUT with oDATA=24'h340479 unchanged, 3 re-issues, then oError=1 with oIndex=3.
- No response: iReady stays 1 after GO at index 0. Required: WAIT_BUSY timeout, 3 retries, then ERROR. Asserting iStart afterwards restarts at oDATA=24'h341E00.
- Recovery: index 5 stalls on its first attempt only. Required: one re-issue, then continuation to index 6 with retry reset (index 6 later tolerates 3 retries).
- Reset mid-run: pull reset low during WAIT_DONE of index 7. Required: all outputs at reset values asynchronously; after release, GO on cycle 2 with index 0.
- iStart pulses during WAIT_DONE are ignored. iStart in DONE re-sends all 11 entries.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: FSM states,
// codec register map and the default I2C write address.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StGap,
        StDone,
        StError
    } cfg_state_e;

    localparam logic [7:0] DefaultDevAddr = 8'h34;

    // WM8731 register addresses (7-bit)
    localparam logic [6:0] RegLeftLineIn  = 7'h00;
    localparam logic [6:0] RegRightLineIn = 7'h01;
    localparam logic [6:0] RegLeftHp      = 7'h02;
    localparam logic [6:0] RegRightHp     = 7'h03;
    localparam logic [6:0] RegAnalogPath  = 7'h04;
    localparam logic [6:0] RegDigitalPath = 7'h05;
    localparam logic [6:0] RegPowerDown   = 7'h06;
    localparam logic [6:0] RegDigitalIf   = 7'h07;
    localparam logic [6:0] RegSampling    = 7'h08;
    localparam logic [6:0] RegActive      = 7'h09;
    localparam logic [6:0] RegReset       = 7'h0F;

    function automatic logic [15:0] cfg_entry(input logic [6:0] addr, input logic [8:0] val);
        return {addr, val};
    endfunction

endpackage

// File: rtl/i2c_codec_rom.sv
// Combinational WM8731 configuration table: index -> {reg[6:0], val[8:0]}.
module i2c_codec_rom
    import i2c_cfg_pkg::*;
(
    input  logic [3:0]  index_i,
    output logic [15:0] entry_o
);

    always_comb begin
        entry_o = 16'h0000;
        case (index_i)
            4'd0:    entry_o = cfg_entry(RegReset,       9'h000);
            4'd1:    entry_o = cfg_entry(RegLeftLineIn,  9'h097);
            4'd2:    entry_o = cfg_entry(RegRightLineIn, 9'h097);
            4'd3:    entry_o = cfg_entry(RegLeftHp,      9'h079);
            4'd4:    entry_o = cfg_entry(RegRightHp,     9'h079);
            4'd5:    entry_o = cfg_entry(RegAnalogPath,  9'h012);
            4'd6:    entry_o = cfg_entry(RegDigitalPath, 9'h000);
            4'd7:    entry_o = cfg_entry(RegPowerDown,   9'h000);
            4'd8:    entry_o = cfg_entry(RegDigitalIf,   9'h042);
            4'd9:    entry_o = cfg_entry(RegSampling,    9'h000);
            4'd10:   entry_o = cfg_entry(RegActive,      9'h001);
            default: entry_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/i2c_codec_config.sv
// Walks the codec configuration table, handing one 24-bit word per entry to the
// I2C write serializer, with per-entry timeout/retry and done/error reporting.
module i2c_codec_config
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 11,
    parameter logic [7:0]  DEV_ADDR   = DefaultDevAddr,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 96,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic        iReady,
    output logic        oGO,
    output logic [23:0] oDATA,
    output logic [3:0]  oIndex,
    output logic        oDone,
    output logic        oError
);

    localparam logic [6:0] CntMax      = 7'h7F;
    localparam logic [6:0] TimeoutLast = 7'(TIMEOUT - 1);
    localparam logic [6:0] GapLast     = 7'(GAP_CYCLES - 1);
    localparam logic [3:0] LastIndex   = 4'(NUM_REGS - 1);
    localparam logic [1:0] MaxRetry    = 2'(MAX_RETRY);

    cfg_state_e  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [3:0]  index_q, index_d;
    logic [23:0] data_q, data_d;
    logic [15:0] rom_entry;
    logic        timed_out;

    i2c_codec_rom u_rom (
        .index_i (index_q),
        .entry_o (rom_entry)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + 7'd1;
        retry_d   = retry_q;
        index_d   = index_q;
        data_d    = data_q;
        timed_out = 1'b0;
        oGO       = 1'b0;

        unique case (state_q)
            StLoad: begin
                data_d  = {DEV_ADDR, rom_entry};
                state_d = StIssue;
            end
            StIssue: begin
                oGO     = 1'b1;
                state_d = StWaitBusy;
            end
            // A serializer that is already busy is accepted on the first cycle.
            StWaitBusy: begin
                if (!iReady) begin
                    state_d = StWaitDone;
                end else if (cnt_q >= TimeoutLast) begin
                    timed_out = 1'b1;
                end
            end
            StWaitDone: begin
                if (iReady) begin
                    state_d = StGap;
                end else if (cnt_q >= TimeoutLast) begin
                    timed_out = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q >= GapLast) begin
                    if (index_q == LastIndex) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 4'd1;
                        retry_d = 2'd0;
                        state_d = StLoad;
                    end
                end
            end
            StDone, StError: begin
                if (iStart) begin
                    index_d = 4'd0;
                    retry_d = 2'd0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase

        // Re-issue keeps oDATA untouched; the fresh GO restarts the serializer.
        if (timed_out) begin
            if (retry_q < MaxRetry) begin
                retry_d = retry_q + 2'd1;
                state_d = StIssue;
            end else begin
                state_d = StError;
            end
        end

        if (state_d != state_q) begin
            cnt_d = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLoad;
            cnt_q   <= 7'd0;
            retry_q <= 2'd0;
            index_q <= 4'd0;
            data_q  <= 24'h000000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    assign oDATA  = data_q;
    assign oIndex = index_q;
    assign oDone  = (state_q == StDone);
    assign oError = (state_q == StError);

endmodule
